// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with stall/flush, valid bit and an optional negedge
// instruction capture. Optional hazard counters are enabled by `define IF_ID_PERF_EN.
module if_id_pipe #(
  parameter int              PC_W         = 32,
  parameter int              INST_W       = 32,
  parameter logic [INST_W-1:0] NOP_INST   = 32'h0000_0000,
  parameter int              INST_NEGEDGE = 1,
  parameter int              CNT_W        = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              stall,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [PC_W-1:0]   if_pc4,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   id_pc4,
`ifdef IF_ID_PERF_EN
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`else
  output logic [INST_W-1:0] id_inst
`endif
);

  localparam logic [1:0] ACT_LOAD  = 2'd0;
  localparam logic [1:0] ACT_HOLD  = 2'd1;
  localparam logic [1:0] ACT_FLUSH = 2'd2;

  logic [1:0] act_s;

  // Per-posedge action, flush has priority over stall.
  always_comb begin
    act_s = ACT_LOAD;
    if (flush) begin
      act_s = ACT_FLUSH;
    end else if (stall) begin
      act_s = ACT_HOLD;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // Posedge fields: valid, pc and pc+4.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_pc4   <= '0;
    end else begin
      case (act_s)
        ACT_LOAD: begin
          id_valid <= if_valid;
          id_pc    <= if_pc;
          id_pc4   <= if_pc4;
        end
        ACT_HOLD: begin
          id_valid <= id_valid;
          id_pc    <= id_pc;
          id_pc4   <= id_pc4;
        end
        default: begin
          id_valid <= 1'b0;
          id_pc    <= '0;
          id_pc4   <= '0;
        end
      endcase
    end
  end

  generate
    if (INST_NEGEDGE != 0) begin : g_neg
      logic [1:0] act_q;
      logic       vld_q;

      // Action and fetch qualifier captured at posedge for the negedge update.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          act_q <= ACT_FLUSH;
          vld_q <= 1'b0;
        end else begin
          act_q <= act_s;
          vld_q <= if_valid;
        end
      end

      // Sync imem data is only valid by the falling edge, so sample it there.
      always_ff @(negedge clk or negedge nrst) begin
        if (!nrst) begin
          id_inst <= NOP_INST;
        end else begin
          case (act_q)
            ACT_LOAD: id_inst <= vld_q ? if_inst : NOP_INST;
            ACT_HOLD: id_inst <= id_inst;
            default:  id_inst <= NOP_INST;
          endcase
        end
      end
    end else begin : g_pos
      // Instruction captured together with the other fields.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          id_inst <= NOP_INST;
        end else begin
          case (act_s)
            ACT_LOAD: id_inst <= if_valid ? if_inst : NOP_INST;
            ACT_HOLD: id_inst <= id_inst;
            default:  id_inst <= NOP_INST;
          endcase
        end
      end
    end
  endgenerate

`ifdef IF_ID_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating hazard counters; only reset clears them.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      case (act_s)
        ACT_HOLD:  stall_cnt <= sat_inc(stall_cnt);
        ACT_FLUSH: flush_cnt <= sat_inc(flush_cnt);
        ACT_LOAD:  begin
          if (!if_valid) begin
            bubble_cnt <= sat_inc(bubble_cnt);
          end else begin
            bubble_cnt <= bubble_cnt;
          end
        end
        default: begin
          stall_cnt <= stall_cnt;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Table-driven bench for if_id_pipe: runs a negedge-capture and a posedge-capture
// instance side by side on identical stimulus.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        stall, flush, if_valid;
  logic [31:0] if_pc, if_pc4, if_inst;

  logic        n_valid, p_valid;
  logic [31:0] n_pc, n_pc4, n_inst, p_pc, p_pc4, p_inst;
`ifdef IF_ID_PERF_EN
  logic [3:0]  n_scnt, n_fcnt, n_bcnt, p_scnt, p_fcnt, p_bcnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_pipe #(.INST_NEGEDGE(1), .CNT_W(4)) u_neg (
    .clk(clk), .nrst(nrst), .stall(stall), .flush(flush), .if_valid(if_valid),
    .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst),
    .id_valid(n_valid), .id_pc(n_pc), .id_pc4(n_pc4),
`ifdef IF_ID_PERF_EN
    .id_inst(n_inst), .stall_cnt(n_scnt), .flush_cnt(n_fcnt), .bubble_cnt(n_bcnt)
`else
    .id_inst(n_inst)
`endif
  );

  if_id_pipe #(.INST_NEGEDGE(0), .CNT_W(4)) u_pos (
    .clk(clk), .nrst(nrst), .stall(stall), .flush(flush), .if_valid(if_valid),
    .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst),
    .id_valid(p_valid), .id_pc(p_pc), .id_pc4(p_pc4),
`ifdef IF_ID_PERF_EN
    .id_inst(p_inst), .stall_cnt(p_scnt), .flush_cnt(p_fcnt), .bubble_cnt(p_bcnt)
`else
    .id_inst(p_inst)
`endif
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic v,
                       input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] inst);
    stall = s; flush = f; if_valid = v; if_pc = pc; if_pc4 = pc4; if_inst = inst;
  endtask

  task automatic chk_all_clear(input string tag);
    chk({tag, "_n_valid"}, {31'd0, n_valid}, 32'd0);
    chk({tag, "_n_pc"}, n_pc, 32'd0);
    chk({tag, "_n_pc4"}, n_pc4, 32'd0);
    chk({tag, "_n_inst"}, n_inst, NOP);
    chk({tag, "_p_valid"}, {31'd0, p_valid}, 32'd0);
    chk({tag, "_p_pc"}, p_pc, 32'd0);
    chk({tag, "_p_pc4"}, p_pc4, 32'd0);
    chk({tag, "_p_inst"}, p_inst, NOP);
  endtask

  logic [31:0] prev_inst;

  initial begin
    //           stall flush valid pc        pc4       inst           e_v  e_pc      e_pc4     e_inst
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h10, 32'h14, 32'h8C01_0004, 1'b1, 32'h10, 32'h14, 32'h8C01_0004};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h18, 32'h1C, 32'hAC02_0008, 1'b1, 32'h10, 32'h14, 32'h8C01_0004};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h18, 32'h1C, 32'hAC02_0008, 1'b1, 32'h10, 32'h14, 32'h8C01_0004};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h18, 32'h1C, 32'hAC02_0008, 1'b1, 32'h10, 32'h14, 32'h8C01_0004};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h18, 32'h1C, 32'hAC02_0008, 1'b1, 32'h18, 32'h1C, 32'hAC02_0008};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h20, 32'h24, 32'h1234_5678, 1'b0, 32'h00, 32'h00, NOP};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h24, 32'h28, 32'hFFFF_FFFF, 1'b0, 32'h24, 32'h28, NOP};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h28, 32'h2C, 32'h2008_0005, 1'b1, 32'h28, 32'h2C, 32'h2008_0005};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h30, 32'h34, 32'hFFFF_FFFF, 1'b1, 32'h28, 32'h2C, 32'h2008_0005};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h30, 32'h34, 32'h0123_4567, 1'b0, 32'h00, 32'h00, NOP};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h30, 32'h34, 32'h0123_4567, 1'b1, 32'h30, 32'h34, 32'h0123_4567};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h40, 32'h44, 32'h2008_0005, 1'b1, 32'h40, 32'h44, 32'h2008_0005};

    nrst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    chk_all_clear("reset");
`ifdef IF_ID_PERF_EN
    chk("reset_n_scnt", {28'd0, n_scnt}, 32'd0);
    chk("reset_p_fcnt", {28'd0, p_fcnt}, 32'd0);
`endif
    @(negedge clk); #1;
    nrst = 1'b1;
    prev_inst = NOP;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].pc, vecs[i].pc4, vecs[i].inst);
      @(posedge clk); #1;
      chk($sformatf("v%0d_n_valid", i), {31'd0, n_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_n_pc", i), n_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_n_pc4", i), n_pc4, vecs[i].e_pc4);
      chk($sformatf("v%0d_n_inst_lag", i), n_inst, prev_inst);
      chk($sformatf("v%0d_p_valid", i), {31'd0, p_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_p_pc", i), p_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_p_pc4", i), p_pc4, vecs[i].e_pc4);
      chk($sformatf("v%0d_p_inst", i), p_inst, vecs[i].e_inst);
      @(negedge clk); #1;
      chk($sformatf("v%0d_n_inst", i), n_inst, vecs[i].e_inst);
      prev_inst = vecs[i].e_inst;
    end

    // Asynchronous reset in the middle of the high phase.
    @(posedge clk); #2;
    chk("midrst_pre_inst", n_inst, 32'h2008_0005);
    nrst = 1'b0;
    #1;
    chk_all_clear("midrst");
    @(negedge clk); #1;
    chk("midrst_neg_inst", n_inst, NOP);

    // Counter sequence: 20 stalls, 2 flushes, 1 invalid load.
    drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h54, 32'h1111_1111);
    nrst = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h60, 32'h64, 32'h2222_2222);
      @(negedge clk); #1;
    end
    chk("perf_hold_n_pc", n_pc, 32'h50);
    chk("perf_hold_n_inst", n_inst, 32'h1111_1111);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h60, 32'h64, 32'h2222_2222);
      @(negedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h70, 32'h74, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'h84, 32'h3333_3333);
    @(negedge clk); #1;
    chk("perf_end_n_inst", n_inst, 32'h3333_3333);
    chk("perf_end_p_pc", p_pc, 32'h80);
`ifdef IF_ID_PERF_EN
    chk("n_stall_cnt", {28'd0, n_scnt}, 32'h0000_000F);
    chk("n_flush_cnt", {28'd0, n_fcnt}, 32'd2);
    chk("n_bubble_cnt", {28'd0, n_bcnt}, 32'd1);
    chk("p_stall_cnt", {28'd0, p_scnt}, 32'h0000_000F);
    chk("p_flush_cnt", {28'd0, p_fcnt}, 32'd2);
    chk("p_bubble_cnt", {28'd0, p_bcnt}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
